// File: rtl/sonic_obstacle_guard.sv
// sonic_obstacle_guard
//   Consumes the ultrasonic ranger's 6-bit distance (cm) and turns it into a
//   debounced, hysteretic obstacle flag for the motion controller.
//   Samples once per SAMPLE_PERIOD, drops zero readings, keeps a 4-sample
//   moving average, and runs a confirm/hysteresis FSM on valid averages.
//
// Optional feature: define SONIC_GUARD_STALE_EN to enable the stale-sensor
//   fault (STALE_LIMIT consecutive zero samples force obstacle=1).
//   Without it, stale is tied 0 and zero samples are simply skipped.
//
// Ports:
//   c1MHz        in   1 MHz clock, rising edge
//   rst          in   asynchronous, active-high reset
//   distance     in   [5:0] ranger output in cm, 0 = invalid
//   sample_tick  out  one-cycle pulse on the cycle distance is sampled
//   avg_distance out  [5:0] floor(mean of last 4 valid samples)
//   avg_valid    out  window holds 4 valid samples
//   obstacle     out  debounced obstacle flag
//   stale        out  stale-sensor fault (0 without SONIC_GUARD_STALE_EN)

module sonic_obstacle_guard #(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int NEAR_CM       = 15,
    parameter int FAR_CM        = 20,
    parameter int CONFIRM       = 3,
    parameter int STALE_LIMIT   = 4
) (
    input  logic       c1MHz,
    input  logic       rst,
    input  logic [5:0] distance,
    output logic       sample_tick,
    output logic [5:0] avg_distance,
    output logic       avg_valid,
    output logic       obstacle,
    output logic       stale
);

    if (SAMPLE_PERIOD < 2 || SAMPLE_PERIOD > 131072 || NEAR_CM > FAR_CM ||
        FAR_CM > 63 || NEAR_CM < 0 || CONFIRM < 1 || CONFIRM > 7 ||
        STALE_LIMIT < 1 || STALE_LIMIT > 15) begin : g_bad_params
        $error("sonic_obstacle_guard: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        NEAR_PEND = 2'd1,
        BLOCKED   = 2'd2,
        FAR_PEND  = 2'd3
    } state_t;

    localparam logic [16:0] LP_LAST    = 17'(SAMPLE_PERIOD - 1);
    localparam logic [5:0]  LP_NEAR    = 6'(NEAR_CM);
    localparam logic [5:0]  LP_FAR     = 6'(FAR_CM);
    localparam logic [2:0]  LP_CONFIRM = 3'(CONFIRM);

    logic [16:0]     r_period;
    logic [3:0][5:0] r_win;        // [0] newest sample
    logic [2:0]      r_fill;
    logic            r_upd_pend;   // valid sample landed; average next edge
    logic            r_avg_upd;
    logic [5:0]      r_avg;
    logic            r_avg_valid;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;
    logic            r_obstacle;

    logic       w_tick;
    logic       w_valid_smp;
    logic       w_eval;
    logic       w_near;
    logic       w_far;
    logic       w_stale_hit;
    logic [7:0] w_sum;

    assign w_tick      = (r_period == LP_LAST);
    assign w_valid_smp = w_tick && (distance != 6'd0);

    // ---------------- period counter ----------------
    always_ff @(posedge c1MHz or posedge rst) begin
        if (rst)         r_period <= '0;
        else if (w_tick) r_period <= '0;
        else             r_period <= r_period + 17'd1;
    end

    // ---------------- sample window ----------------
    always_ff @(posedge c1MHz or posedge rst) begin
        if (rst) begin
            r_win      <= '0;
            r_fill     <= '0;
            r_upd_pend <= 1'b0;
        end else begin
            r_upd_pend <= w_valid_smp;
            if (w_valid_smp) begin
                r_win  <= {r_win[2:0], distance};
                r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
            end
        end
    end

    // ---------------- averaging ----------------
    // Unfilled entries are 0, so early averages read low; avg_valid gates them.
    assign w_sum = 8'(r_win[0]) + 8'(r_win[1]) + 8'(r_win[2]) + 8'(r_win[3]);

    always_ff @(posedge c1MHz or posedge rst) begin
        if (rst) begin
            r_avg_upd   <= 1'b0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_upd <= r_upd_pend;
            if (r_upd_pend) begin
                r_avg       <= 6'(w_sum >> 2);
                r_avg_valid <= (r_fill == 3'd4);
            end
        end
    end

    // ---------------- stale fault ----------------
`ifdef SONIC_GUARD_STALE_EN
    localparam logic [3:0] LP_STALE_HIT = 4'(STALE_LIMIT - 1);

    logic [3:0] r_stale_cnt;
    logic       r_stale;

    // Fires once, on the tick edge where the count reaches STALE_LIMIT.
    assign w_stale_hit = w_tick && (distance == 6'd0) && (r_stale_cnt == LP_STALE_HIT);

    always_ff @(posedge c1MHz or posedge rst) begin
        if (rst) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (w_valid_smp) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (w_tick) begin
            if (r_stale_cnt != 4'd15) r_stale_cnt <= r_stale_cnt + 4'd1;
            if (w_stale_hit)          r_stale     <= 1'b1;
        end
    end

    assign stale = r_stale;
`else
    assign w_stale_hit = 1'b0;
    assign stale       = 1'b0;
`endif

    // ---------------- obstacle FSM ----------------
    assign w_eval = r_avg_upd && r_avg_valid;
    assign w_near = (r_avg < LP_NEAR);
    assign w_far  = (r_avg > LP_FAR);

    always_ff @(posedge c1MHz or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_obstacle <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_obstacle <= (w_state_nxt == BLOCKED) || (w_state_nxt == FAR_PEND);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_stale_hit) begin
            // fault overrides any same-edge average evaluation
            w_state_nxt = BLOCKED;
            w_cnt_nxt   = '0;
        end else if (w_eval) begin
            case (r_state)
                CLEAR: if (w_near) begin
                    if (LP_CONFIRM == 3'd1) begin
                        w_state_nxt = BLOCKED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = NEAR_PEND;
                        w_cnt_nxt   = 3'd1;
                    end
                end
                NEAR_PEND: begin
                    if (!w_near) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt + 3'd1 == LP_CONFIRM) begin
                        w_state_nxt = BLOCKED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                BLOCKED: if (w_far) begin
                    if (LP_CONFIRM == 3'd1) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = FAR_PEND;
                        w_cnt_nxt   = 3'd1;
                    end
                end
                FAR_PEND: begin
                    if (!w_far) begin
                        w_state_nxt = BLOCKED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt + 3'd1 == LP_CONFIRM) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign sample_tick  = w_tick;
    assign avg_distance = r_avg;
    assign avg_valid    = r_avg_valid;
    assign obstacle     = r_obstacle;

endmodule

// File: tb/tb_sonic_obstacle_guard.sv
// Directed self-checking bench for sonic_obstacle_guard.
// u_dut: SAMPLE_PERIOD=10, NEAR=15, FAR=20, CONFIRM=3, STALE_LIMIT=4.
// u_min: SAMPLE_PERIOD=2, NEAR=FAR=30, CONFIRM=1 (minimum settings).
module tb_sonic_obstacle_guard;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] distance;
    logic       sample_tick;
    logic [5:0] avg_distance;
    logic       avg_valid;
    logic       obstacle;
    logic       stale;

    logic [5:0] d2;
    logic       tick2;
    logic [5:0] avg2;
    logic       valid2;
    logic       obs2;
    logic       stale2;

    int nassert = 0;
    int nfail   = 0;

    // values captured inside tick_with
    logic       c0_obs, c0_stale, c1_obs;
    logic [5:0] c0_avg;

    always #5 clk = ~clk;

    sonic_obstacle_guard #(
        .SAMPLE_PERIOD(10), .NEAR_CM(15), .FAR_CM(20), .CONFIRM(3), .STALE_LIMIT(4)
    ) u_dut (
        .c1MHz(clk), .rst(rst), .distance(distance), .sample_tick(sample_tick),
        .avg_distance(avg_distance), .avg_valid(avg_valid), .obstacle(obstacle), .stale(stale)
    );

    sonic_obstacle_guard #(
        .SAMPLE_PERIOD(2), .NEAR_CM(30), .FAR_CM(30), .CONFIRM(1), .STALE_LIMIT(4)
    ) u_min (
        .c1MHz(clk), .rst(rst), .distance(d2), .sample_tick(tick2),
        .avg_distance(avg2), .avg_valid(valid2), .obstacle(obs2), .stale(stale2)
    );

    // Present v for the next tick. Returns at the negedge two edges after the
    // tick edge. Captures outputs half a cycle after the tick edge (c0_*) and
    // after the following edge (c1_obs). A junk value is driven between ticks.
    task automatic tick_with(input logic [5:0] v);
        int n = 0;
        distance = v;
        while (sample_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        nassert++;
        if (sample_tick !== 1'b1) begin
            nfail++;
            $display("FAIL tick_timeout: sample_tick=%b required 1", sample_tick);
        end
        @(posedge clk);
        @(negedge clk);
        distance = 6'd55;
        c0_obs   = obstacle;
        c0_stale = stale;
        c0_avg   = avg_distance;
        @(negedge clk);
        c1_obs = obstacle;
        @(negedge clk);
    endtask

    // Same idea for u_min; drives 0 between ticks so nothing extra is sampled.
    task automatic tick2_with(input logic [5:0] v);
        int n = 0;
        d2 = v;
        while (tick2 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        nassert++;
        if (tick2 !== 1'b1) begin
            nfail++;
            $display("FAIL tick2_timeout: sample_tick=%b required 1", tick2);
        end
        @(posedge clk);
        @(negedge clk);
        d2 = 6'd0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        distance = 6'd40;
        d2       = 6'd40;
        #1 rst = 1'b1;
        #2;
        nassert++;
        if ({sample_tick, avg_distance, avg_valid, obstacle, stale} !== 10'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got tick=%b avg=%0d valid=%b obs=%b stale=%b required all 0",
                     sample_tick, avg_distance, avg_valid, obstacle, stale);
        end
        nassert++;
        if ({tick2, avg2, valid2, obs2, stale2} !== 10'd0) begin
            nfail++;
            $display("FAIL reset_outputs_min: got tick=%b avg=%0d valid=%b obs=%b stale=%b required all 0",
                     tick2, avg2, valid2, obs2, stale2);
        end
    endtask

    // distance=40 held from reset release: ticks at cycles 9,19,29,39
    task automatic test_sampling;
        logic       e_tick, e_valid;
        logic [5:0] e_avg;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 45; i++) begin
            e_tick  = (i % 10 == 9);
            e_valid = (i >= 41);
            e_avg   = (i < 11) ? 6'd0 : (i < 21) ? 6'd10 : (i < 31) ? 6'd20 :
                      (i < 41) ? 6'd30 : 6'd40;
            nassert++;
            if (sample_tick !== e_tick) begin
                nfail++;
                $display("FAIL sampling_tick cycle %0d: got %b required %b", i, sample_tick, e_tick);
            end
            nassert++;
            if (avg_valid !== e_valid) begin
                nfail++;
                $display("FAIL sampling_valid cycle %0d: got %b required %b", i, avg_valid, e_valid);
            end
            nassert++;
            if (avg_distance !== e_avg) begin
                nfail++;
                $display("FAIL sampling_avg cycle %0d: got %0d required %0d", i, avg_distance, e_avg);
            end
            nassert++;
            if (obstacle !== 1'b0) begin
                nfail++;
                $display("FAIL sampling_obs cycle %0d: got %b required 0", i, obstacle);
            end
            if (i < 45) @(negedge clk);
        end
    endtask

    // window full of 40 -> six samples of 10
    task automatic test_entry_debounce;
        logic [5:0] e_avg [6];
        logic       e_obs [6];
        e_avg = '{6'd32, 6'd25, 6'd17, 6'd10, 6'd10, 6'd10};
        e_obs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            tick_with(6'd10);
            if (k == 0) begin
                nassert++;
                if (c0_avg !== 6'd40) begin
                    nfail++;
                    $display("FAIL entry_avg_latency: got %0d at tick edge required old 40", c0_avg);
                end
            end
            nassert++;
            if (avg_distance !== e_avg[k]) begin
                nfail++;
                $display("FAIL entry_avg step %0d: got %0d required %0d", k, avg_distance, e_avg[k]);
            end
            nassert++;
            if (obstacle !== e_obs[k]) begin
                nfail++;
                $display("FAIL entry_obs step %0d: got %b required %b", k, obstacle, e_obs[k]);
            end
        end
        nassert++;
        if (c1_obs !== 1'b0) begin
            nfail++;
            $display("FAIL entry_obs_latency: got %b one edge after tick required 0", c1_obs);
        end
    endtask

    // from BLOCKED with window of 10s: hold at 20, then 21,21,15,21,21,21
    task automatic test_hysteresis;
        logic [5:0] dv    [14];
        logic [5:0] e_avg [14];
        logic       e_obs [14];
        dv    = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd26, 6'd29, 6'd24, 6'd1,
                  6'd30, 6'd29, 6'd1, 6'd24, 6'd30, 6'd29};
        e_avg = '{6'd7, 6'd5, 6'd3, 6'd1, 6'd7, 6'd14, 6'd20, 6'd20,
                  6'd21, 6'd21, 6'd15, 6'd21, 6'd21, 6'd21};
        e_obs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 14; k++) begin
            tick_with(dv[k]);
            nassert++;
            if (avg_distance !== e_avg[k]) begin
                nfail++;
                $display("FAIL hyst_avg step %0d: got %0d required %0d", k, avg_distance, e_avg[k]);
            end
            nassert++;
            if (obstacle !== e_obs[k]) begin
                nfail++;
                $display("FAIL hyst_obs step %0d: got %b required %b", k, obstacle, e_obs[k]);
            end
        end
    endtask

    task automatic test_invalid;
        logic [5:0] e_avg [4];
        e_avg = '{6'd30, 6'd34, 6'd37, 6'd40};
        for (int k = 0; k < 4; k++) begin
            tick_with(6'd40);
            nassert++;
            if (avg_distance !== e_avg[k] || obstacle !== 1'b0) begin
                nfail++;
                $display("FAIL invalid_fill step %0d: got avg=%0d obs=%b required avg=%0d obs=0",
                         k, avg_distance, obstacle, e_avg[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick_with(6'd0);
            nassert++;
            if (avg_distance !== 6'd40 || obstacle !== 1'b0 || stale !== 1'b0 || avg_valid !== 1'b1) begin
                nfail++;
                $display("FAIL invalid_skip %0d: got avg=%0d obs=%b stale=%b valid=%b required 40/0/0/1",
                         k, avg_distance, obstacle, stale, avg_valid);
            end
        end
`ifdef SONIC_GUARD_STALE_EN
        tick_with(6'd0);
        nassert++;
        if (c0_stale !== 1'b1 || c0_obs !== 1'b1) begin
            nfail++;
            $display("FAIL stale_set: got stale=%b obs=%b on tick edge required 1/1", c0_stale, c0_obs);
        end
        for (int k = 0; k < 3; k++) begin
            tick_with(6'd40);
            nassert++;
            if (c0_stale !== 1'b0) begin
                nfail++;
                $display("FAIL stale_clear %0d: got stale=%b required 0", k, c0_stale);
            end
            nassert++;
            if (obstacle !== (k < 2)) begin
                nfail++;
                $display("FAIL stale_recover %0d: got obs=%b required %b", k, obstacle, (k < 2));
            end
        end
`endif
        // a zero must not have entered the window: [40,40,40,20] -> 35
        tick_with(6'd20);
        nassert++;
        if (avg_distance !== 6'd35 || obstacle !== 1'b0 || stale !== 1'b0) begin
            nfail++;
            $display("FAIL invalid_window: got avg=%0d obs=%b stale=%b required 35/0/0",
                     avg_distance, obstacle, stale);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] dv    [7];
        logic [5:0] e_avg [7];
        logic       e_obs [7];
        dv    = '{6'd10, 6'd10, 6'd10, 6'd10, 6'd10, 6'd40, 6'd40};
        e_avg = '{6'd27, 6'd20, 6'd12, 6'd10, 6'd10, 6'd17, 6'd25};
        e_obs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            tick_with(dv[k]);
            nassert++;
            if (avg_distance !== e_avg[k] || obstacle !== e_obs[k]) begin
                nfail++;
                $display("FAIL resetmid_setup %0d: got avg=%0d obs=%b required avg=%0d obs=%b",
                         k, avg_distance, obstacle, e_avg[k], e_obs[k]);
            end
        end
        // now in FAR_PEND; assert reset between clock edges
        #2 rst = 1'b1;
        #1;
        nassert++;
        if ({sample_tick, avg_distance, avg_valid, obstacle, stale} !== 10'd0) begin
            nfail++;
            $display("FAIL resetmid_async: got tick=%b avg=%0d valid=%b obs=%b stale=%b required all 0",
                     sample_tick, avg_distance, avg_valid, obstacle, stale);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick_with(6'd40);
            nassert++;
            if (avg_valid !== (k == 3) || avg_distance !== 6'(10 * (k + 1)) || obstacle !== 1'b0) begin
                nfail++;
                $display("FAIL resetmid_refill %0d: got valid=%b avg=%0d obs=%b required %b/%0d/0",
                         k, avg_valid, avg_distance, obstacle, (k == 3), 10 * (k + 1));
            end
        end
    endtask

    // CONFIRM=1, NEAR=FAR=30; window starts full of 40
    task automatic test_min_settings;
        logic [5:0] dv    [8];
        logic [5:0] e_avg [8];
        logic       e_obs [8];
        dv    = '{6'd29, 6'd29, 6'd29, 6'd29, 6'd35, 6'd33, 6'd25, 6'd20};
        e_avg = '{6'd37, 6'd34, 6'd31, 6'd29, 6'd30, 6'd31, 6'd30, 6'd28};
        e_obs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            tick2_with(dv[k]);
            nassert++;
            if (avg2 !== e_avg[k]) begin
                nfail++;
                $display("FAIL min_avg step %0d: got %0d required %0d", k, avg2, e_avg[k]);
            end
            nassert++;
            if (obs2 !== e_obs[k]) begin
                nfail++;
                $display("FAIL min_obs step %0d: got %b required %b", k, obs2, e_obs[k]);
            end
        end
        nassert++;
        if (valid2 !== 1'b1 || stale2 !== 1'b0) begin
            nfail++;
            $display("FAIL min_flags: got valid=%b stale=%b required 1/0", valid2, stale2);
        end
    endtask

    initial begin
        test_reset();
        test_sampling();
        test_entry_debounce();
        test_hysteresis();
        test_invalid();
        test_reset_mid();
        test_min_settings();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/sonic_obstacle_guard.md
Name: sonic_obstacle_guard

Overview:
- Downstream consumer of the ultrasonic ranger's 6-bit `distance` output (cm), running in the same 1 MHz domain.
- Samples the distance once per measurement period and discards zero readings (no echo / ranger in reset).
- Smooths valid readings with a 4-sample moving average.
- Drives a debounced, hysteretic `obstacle` flag for the motion controller.

Parameters:
- SAMPLE_PERIOD, 100000: c1MHz cycles between samples; matches the ranger trigger period. Legal range 2..131072.
- NEAR_CM, 15: `obstacle` asserts when avg < NEAR_CM (confirmed).
- FAR_CM, 20: `obstacle` deasserts when avg > FAR_CM (confirmed). Required: NEAR_CM <= FAR_CM <= 63.
- CONFIRM, 3: consecutive qualifying averages needed to change state. Legal range 1..7.
- STALE_LIMIT, 4: consecutive invalid samples before a stale fault. Used only with the optional feature. Legal range 1..15.

Ports:
- c1MHz  in  1  1 MHz clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- distance  in  6  ranger output, cm; 0 = invalid.
- sample_tick  out  1  one-cycle pulse on the cycle `distance` is sampled.
- avg_distance  out  6  floor of the mean of the last 4 valid samples.
- avg_valid  out  1  high once 4 valid samples have been taken.
- obstacle  out  1  debounced obstacle flag.
- stale  out  1  stale-sensor fault; tied 0 without the optional feature.

Behaviour:
- Reset: all outputs are 0.
  - Period counter, window, fill count, confirm count and stale count are 0.
  - FSM is in CLEAR.
  - Reset mid-operation aborts everything; nothing is held over.
- Period counter (17-bit):
  - Counts 0..SAMPLE_PERIOD-1, then wraps to 0.
  - `sample_tick` = 1 while the count equals SAMPLE_PERIOD-1.
  - The first tick occurs SAMPLE_PERIOD cycles after reset release.
- Sampling, on the tick edge:
  - `distance` != 0:
    - Shift it into a 4-entry window (newest in, oldest out).
    - Fill count increments, saturating at 4.
    - Stale count clears.
  - `distance` == 0:
    - Window and fill count are unchanged.
    - Stale count increments, saturating at 15.
- Averaging:
  - On the edge after a tick that carried a valid sample:
    - sum = 8-bit sum of the 4 entries (max 252, no overflow).
    - `avg_distance` = sum >> 2.
    - `avg_valid` = (fill == 4).
    - Internal strobe `avg_upd` pulses for one cycle.
  - Unfilled entries count as 0, so early averages read low. `avg_valid` gates their use.
  - Latency: from the tick edge to `avg_distance` is 1 cycle; from the tick edge to an `obstacle` change is 2 cycles.
  - An invalid sample produces no `avg_upd`.
- FSM, evaluated only on `avg_upd` with `avg_valid` = 1:
  - Definitions:
    - near = avg < NEAR_CM
    - far = avg > FAR_CM
    - avg == NEAR_CM is not near.
    - avg == FAR_CM is not far.
    - Values inside the band hold the current state.
  - CLEAR: on near, cnt = 1; go to BLOCKED if CONFIRM == 1, else NEAR_PEND.
  - NEAR_PEND:
    - Near: cnt++; go to BLOCKED when cnt reaches CONFIRM.
    - Not near: go to CLEAR, cnt = 0.
  - BLOCKED: on far, cnt = 1; go to CLEAR if CONFIRM == 1, else FAR_PEND.
  - FAR_PEND:
    - Far: cnt++; go to CLEAR when cnt reaches CONFIRM.
    - Not far: go to BLOCKED, cnt = 0.
  - `obstacle` = 1 in BLOCKED and FAR_PEND; registered; changes on the same edge as the state.
- A `distance` change between ticks is ignored; only the value present on the tick cycle counts.

Optional Feature:
- Macro: SONIC_GUARD_STALE_EN.
- Defined:
  - When the stale count reaches STALE_LIMIT, `stale` = 1 and the FSM is forced to BLOCKED (cnt = 0), so `obstacle` = 1, on the same edge.
  - The next valid sample clears `stale` on its tick edge. The FSM stays BLOCKED until far is confirmed normally.
  - Window contents are retained through the fault.
- Not defined:
  - Invalid samples are only skipped.
  - `stale` is constant 0.
  - Stale-count logic is absent.

Test Plan:
- Sampling: SAMPLE_PERIOD = 10, `distance` = 40 held -> `sample_tick` at cycles 9, 19, 29, 39. `avg_valid` rises one cycle after the 4th tick with `avg_distance` = 40; `obstacle` stays 0.
- Entry debounce: fill with 40, then valid samples 10, 10, 10, 10 (CONFIRM = 3) -> averages 32, 25, 17, 10. Near only at 10 -> `obstacle` not yet 1. Two more ticks of 10 -> `obstacle` = 1, 2 cycles after the 3rd near tick.
- Hysteresis boundaries: in BLOCKED, hold averages at 20 -> `obstacle` stays 1. Averages 21, 21, 15, 21, 21, 21 -> the 15 resets confirmation; `obstacle` = 0 only after the last 21.
- Invalid samples: steady 40, insert three `distance` = 0 ticks -> no `avg_upd`, `avg_distance` unchanged at 40, `obstacle` 0. With SONIC_GUARD_STALE_EN and STALE_LIMIT = 4, a fourth 0 -> `stale` = 1 and `obstacle` = 1 on that tick edge; a valid 40 then clears `stale`, but `obstacle` holds until 3 far averages.
- Reset mid-operation: assert `rst` asynchronously while in FAR_PEND -> all outputs 0 immediately, without a clock edge. After release, `avg_valid` needs 4 fresh valid samples.
- Minimum settings: CONFIRM = 1, SAMPLE_PERIOD = 2, NEAR_CM = FAR_CM = 30 -> an average of 29 sets `obstacle` and 31 clears it, each in one update; 30 holds the current state.
